// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline with divider handshake and watchdog.
//   in : clk, rst, ID read enables/addresses, EX load/write/dest/div request, div_ready_i,
//        mem_req_i/mem_ack_i, exception_i, new_pc_i
//   out: stall_o (bit0 PC .. bit5 WB), flush_o, new_pc_o, div_start_o, div_annul_o, err_o, state_o
module pipeline_ctrl #(
   parameter int DIV_MAX_CYCLES = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_reg1_read_i,
   input  logic        id_reg2_read_i,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic        ex_rmem_i,
   input  logic        ex_wreg_i,
   input  logic [4:0]  ex_wd_i,
   input  logic        ex_div_req_i,
   input  logic        div_ready_i,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   input  logic        exception_i,
   input  logic [31:0] new_pc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        err_o,
   output logic [1:0]  state_o
);
   localparam int CW = $clog2(DIV_MAX_CYCLES);
   localparam logic [5:0] ST_MEM = 6'b011111;
   localparam logic [5:0] ST_DIV = 6'b001111;
   localparam logic [5:0] ST_LU  = 6'b000111;
   typedef enum logic [1:0] {RUN = 2'd0, DIV_WAIT = 2'd1, MEM_WAIT = 2'd2} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic div_done, exc_pend, err;
   logic [31:0] pend_pc;
   logic memwait, loaduse, fin, wd;
   assign memwait = mem_req_i && !mem_ack_i;
   assign loaduse = ex_rmem_i && ex_wreg_i && ex_wd_i != 5'd0 &&
                    ((id_reg1_read_i && id_rs_i == ex_wd_i) || (id_reg2_read_i && id_rt_i == ex_wd_i));
   assign fin = div_done || div_ready_i;
   assign wd = cnt == CW'(DIV_MAX_CYCLES - 1);
   assign err_o = err;
   assign state_o = state;
   always_comb begin
      stall_o = 6'd0;
      flush_o = 1'b0;
      new_pc_o = 32'd0;
      div_start_o = 1'b0;
      div_annul_o = 1'b0;
      nxt = state;
      if (!rst)
         case (state)
            RUN:
               if (exception_i) begin
                  flush_o = 1'b1;
                  new_pc_o = new_pc_i;
               end else if (memwait) begin
                  stall_o = ST_MEM;
                  nxt = MEM_WAIT;
               end else if (ex_div_req_i) begin
                  div_start_o = 1'b1;
                  stall_o = ST_DIV;
                  nxt = DIV_WAIT;
               end else if (loaduse)
                  stall_o = ST_LU;
            DIV_WAIT:
               if (exception_i) begin
                  flush_o = 1'b1;
                  new_pc_o = new_pc_i;
                  div_annul_o = 1'b1;
                  nxt = RUN;
               end else if (memwait)
                  stall_o = ST_MEM;
               else if (fin)
                  nxt = RUN;
               else if (wd) begin
                  div_annul_o = 1'b1;
                  nxt = RUN;
               end else
                  stall_o = ST_DIV;
            MEM_WAIT:
               if (mem_ack_i) begin
                  nxt = RUN;
                  flush_o = exc_pend || exception_i;
                  new_pc_o = flush_o ? (exception_i ? new_pc_i : pend_pc) : 32'd0;
               end else
                  stall_o = ST_MEM;
            default: nxt = RUN;
         endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= RUN;
         cnt <= '0;
         div_done <= 1'b0;
         exc_pend <= 1'b0;
         pend_pc <= 32'd0;
         err <= 1'b0;
      end else begin
         state <= nxt;
         if (div_start_o) begin
            cnt <= '0;
            div_done <= 1'b0;
         end
         if (state == DIV_WAIT) begin
            if (div_ready_i) div_done <= 1'b1;
            if (stall_o == ST_DIV) cnt <= cnt + CW'(1);
            // annul without exception can only be the watchdog
            if (div_annul_o && !exception_i) err <= 1'b1;
         end
         if (state == MEM_WAIT) begin
            exc_pend <= !mem_ack_i && (exc_pend || exception_i);
            if (exception_i) pend_pc <= new_pc_i;
         end
      end
endmodule
